// File: rtl/class_hvec_pkg.sv
// Shared definitions for the class-vector ROM streamer: default sizes,
// address-width helpers and the stream FSM state type.
package class_hvec_pkg;

    localparam int DEF_DI_PARALLEL_W_BITS = 64;
    localparam int DEF_N_CLASSES          = 8;
    localparam int DEF_N_FRAMES           = 3;

    // Address width that never collapses to zero bits for a single entry.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int calc_cid_w(input int n_classes);
        return clog2_min1(n_classes);
    endfunction

    function automatic int calc_fidx_w(input int n_frames);
        return clog2_min1(n_frames);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } stream_state_t;

endpackage

// File: rtl/class_hvec_addr_cnt.sv
// Nested class/frame address counter. The latched order flag picks which of the
// two counters is the inner one; the counters park on the final address.
module class_hvec_addr_cnt
    import class_hvec_pkg::*;
#(
    parameter int N_CLASSES = DEF_N_CLASSES,
    parameter int N_FRAMES  = DEF_N_FRAMES,
    localparam int CID_W    = calc_cid_w(N_CLASSES),
    localparam int FIDX_W   = calc_fidx_w(N_FRAMES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    input  logic              class_major,
    output logic [CID_W-1:0]  class_id,
    output logic [FIDX_W-1:0] frame_idx,
    output logic              last
);

    localparam logic [CID_W-1:0]  CLS_MAX = CID_W'(N_CLASSES - 1);
    localparam logic [FIDX_W-1:0] FRM_MAX = FIDX_W'(N_FRAMES - 1);

    logic major_q;
    logic cls_at_max;
    logic frm_at_max;

    assign cls_at_max = (class_id == CLS_MAX);
    assign frm_at_max = (frame_idx == FRM_MAX);
    assign last       = cls_at_max && frm_at_max;

    // NOTE: every register here uses <= so all counters update from the same
    // pre-edge values; blocking assignments would leak new values into this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            class_id  <= '0;
            frame_idx <= '0;
            major_q   <= 1'b0;
        end else if (clear) begin
            class_id  <= '0;
            frame_idx <= '0;
            major_q   <= class_major;
        end else if (advance && !last) begin
            if (major_q) begin
                // Frame is the inner counter; it carries into the class.
                if (frm_at_max) begin
                    frame_idx <= '0;
                    class_id  <= class_id + 1'b1;
                end else begin
                    frame_idx <= frame_idx + 1'b1;
                end
            end else begin
                if (cls_at_max) begin
                    class_id  <= '0;
                    frame_idx <= frame_idx + 1'b1;
                end else begin
                    class_id  <= class_id + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/class_hvec_streamer.sv
// Reader side of the class-vector ROM: walks every (class, frame) address,
// registers each ROM slice and presents it on a valid/ready stream with tags.
module class_hvec_streamer
    import class_hvec_pkg::*;
#(
    parameter int DI_PARALLEL_W_BITS = DEF_DI_PARALLEL_W_BITS,
    parameter int N_CLASSES          = DEF_N_CLASSES,
    parameter int N_FRAMES           = DEF_N_FRAMES,
    localparam int CID_W             = calc_cid_w(N_CLASSES),
    localparam int FIDX_W            = calc_fidx_w(N_FRAMES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          class_major,
    output logic [CID_W-1:0]              rom_frame_id,
    output logic [FIDX_W-1:0]             rom_frame_index,
    input  logic [DI_PARALLEL_W_BITS-1:0] rom_class_vec,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DI_PARALLEL_W_BITS-1:0] m_data,
    output logic [CID_W-1:0]              m_class_id,
    output logic [FIDX_W-1:0]             m_frame_idx,
    output logic                          m_last_frame,
    output logic                          m_last,
    output logic                          busy,
    output logic                          done
);

    localparam logic [FIDX_W-1:0] FRM_MAX = FIDX_W'(N_FRAMES - 1);

    stream_state_t     state;
    stream_state_t     next_state;
    logic              load;
    logic              clear;
    logic              drop;
    logic              final_accept;
    logic [CID_W-1:0]  addr_class;
    logic [FIDX_W-1:0] addr_frame;
    logic              addr_last;

    class_hvec_addr_cnt #(
        .N_CLASSES (N_CLASSES),
        .N_FRAMES  (N_FRAMES)
    ) u_addr_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .advance     (load),
        .class_major (class_major),
        .class_id    (addr_class),
        .frame_idx   (addr_frame),
        .last        (addr_last)
    );

    assign rom_frame_id    = addr_class;
    assign rom_frame_index = addr_frame;
    assign busy            = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        next_state   = state;
        load         = 1'b0;
        clear        = 1'b0;
        drop         = 1'b0;
        final_accept = 1'b0;
        case (state)
            ST_IDLE: begin
                // Abort has priority over a simultaneous start.
                if (start && !abort) begin
                    clear      = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    drop       = 1'b1;
                    next_state = ST_IDLE;
                end else if (!m_valid || m_ready) begin
                    load = 1'b1;
                    if (addr_last) begin
                        next_state = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    drop       = 1'b1;
                    next_state = ST_IDLE;
                end else if (m_valid && m_ready) begin
                    final_accept = 1'b1;
                    drop         = 1'b1;
                    next_state   = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Output register: a new slice is captured only when the slot is empty or
    // being drained this cycle, so a stalled beat stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_class_id   <= '0;
            m_frame_idx  <= '0;
            m_last_frame <= 1'b0;
            m_last       <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= final_accept;
            if (load) begin
                m_valid      <= 1'b1;
                m_data       <= rom_class_vec;
                m_class_id   <= addr_class;
                m_frame_idx  <= addr_frame;
                m_last_frame <= (addr_frame == FRM_MAX);
                m_last       <= addr_last;
            end else if (drop) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_class_hvec_streamer.sv
// Self-checking bench for class_hvec_streamer: random ROM contents, expected
// beat order built from nested loops, random backpressure, abort and reset cases.
module tb_class_hvec_streamer;

    localparam int DW = 64;
    localparam int NC = 8;
    localparam int NF = 3;
    localparam int CW = 3;
    localparam int FW = 2;
    localparam int NB = NC * NF;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          class_major;
    logic [CW-1:0] rom_frame_id;
    logic [FW-1:0] rom_frame_index;
    logic [DW-1:0] rom_class_vec;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_class_id;
    logic [FW-1:0] m_frame_idx;
    logic          m_last_frame;
    logic          m_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] rom_table [NC][NF];

    typedef struct {
        int cls;
        int frm;
    } addr_t;

    addr_t exp_q [$];
    int    n_cmp;
    int    n_bad;
    int    cyc;
    int    acc;

    class_hvec_streamer #(
        .DI_PARALLEL_W_BITS (DW),
        .N_CLASSES          (NC),
        .N_FRAMES           (NF)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .class_major     (class_major),
        .rom_frame_id    (rom_frame_id),
        .rom_frame_index (rom_frame_index),
        .rom_class_vec   (rom_class_vec),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_class_id      (m_class_id),
        .m_frame_idx     (m_frame_idx),
        .m_last_frame    (m_last_frame),
        .m_last          (m_last),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ROM standing in for class_hvec_gen.
    always_comb begin
        rom_class_vec = '0;
        if (int'(rom_frame_index) < NF) begin
            rom_class_vec = rom_table[rom_frame_id][rom_frame_index];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_order(input bit major);
        exp_q.delete();
        if (major) begin
            for (int c = 0; c < NC; c++)
                for (int f = 0; f < NF; f++)
                    exp_q.push_back('{cls: c, frm: f});
        end else begin
            for (int f = 0; f < NF; f++)
                for (int c = 0; c < NC; c++)
                    exp_q.push_back('{cls: c, frm: f});
        end
    endtask

    function automatic logic [127:0] obs_beat();
        return 128'({m_data, m_class_id, m_frame_idx, m_last, m_last_frame});
    endfunction

    function automatic logic [127:0] exp_beat(input int k);
        addr_t a;
        a = exp_q[k];
        return 128'({rom_table[a.cls][a.frm], CW'(a.cls), FW'(a.frm),
                      (k == NB - 1), (a.frm == NF - 1)});
    endfunction

    // Runs one full sweep from a step point; returns on the cycle done is seen,
    // so a following call exercises start in the done cycle.
    task automatic run_sweep(input bit major, input bit rand_ready,
                             input int restart_at, output int cycles);
        logic [127:0] held;
        bit           stalled;
        bit           finished;
        int           idx;
        build_order(major);
        class_major = major;
        start       = 1'b1;
        m_ready     = 1'b0;
        tick();
        start       = 1'b0;
        class_major = ~major;
        chk1("busy_after_start", busy, 1'b1);
        chk1("done_single_pulse", done, 1'b0);
        chk1("first_beat_latency", m_valid, 1'b0);
        chkw("rom_addr_cleared", 128'({rom_frame_id, rom_frame_index}), 128'(0));
        idx      = 0;
        stalled  = 1'b0;
        finished = 1'b0;
        held     = '0;
        cycles   = 0;
        while (!finished && cycles < 1000) begin
            if (stalled) begin
                chk1("stall_valid_held", m_valid, 1'b1);
                chkw("stall_beat_held", obs_beat(), held);
            end
            if (idx == NB) begin
                chk1("done_after_last", done, 1'b1);
                chk1("busy_after_last", busy, 1'b0);
                chk1("valid_after_last", m_valid, 1'b0);
                finished = 1'b1;
            end else begin
                chk1("no_early_done", done, 1'b0);
                start   = (cycles == restart_at);
                m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (m_valid && m_ready) begin
                    chkw($sformatf("beat_%0d", idx), obs_beat(), exp_beat(idx));
                    idx++;
                end
                stalled = m_valid && !m_ready;
                held    = obs_beat();
                tick();
                cycles++;
            end
        end
        start   = 1'b0;
        m_ready = 1'b0;
        chk1("sweep_finished", finished, 1'b1);
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        start       = 1'b0;
        abort       = 1'b0;
        class_major = 1'b0;
        m_ready     = 1'b0;
        rst_n       = 1'b1;
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++)
                rom_table[c][f] = {$urandom, $urandom};

        #1 rst_n = 1'b0;
        #1;
        chk1("reset_valid", m_valid, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chkw("reset_beat", obs_beat(), 128'(0));
        chkw("reset_rom_addr", 128'({rom_frame_id, rom_frame_index}), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_valid", m_valid, 1'b0);

        // Full-rate sweeps; a start issued mid-sweep must not disturb the first.
        run_sweep(1'b1, 1'b0, 5, cyc);
        chkw("class_major_cycles", 128'(cyc), 128'(NB + 1));
        run_sweep(1'b0, 1'b0, -1, cyc);
        chkw("frame_major_cycles", 128'(cyc), 128'(NB + 1));

        // Random backpressure in both orders.
        run_sweep(1'b1, 1'b1, -1, cyc);
        run_sweep(1'b0, 1'b1, 7, cyc);
        tick();
        chk1("done_drops", done, 1'b0);

        // Abort while beat 10 is stalled.
        build_order(1'b1);
        class_major = 1'b1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        acc   = 0;
        cyc   = 0;
        while (acc < 9 && cyc < 100) begin
            m_ready = 1'b1;
            if (m_valid) acc++;
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        chk1("abort_beat10_valid", m_valid, 1'b1);
        chkw("abort_beat10_data", obs_beat(), exp_beat(9));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abort_valid", m_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_no_done", done, 1'b0);
        tick();
        chk1("abort_no_done_later", done, 1'b0);
        run_sweep(1'b0, 1'b0, -1, cyc);
        chkw("after_abort_cycles", 128'(cyc), 128'(NB + 1));
        tick();

        // Start and abort together: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk1("start_abort_busy", busy, 1'b0);
        chk1("start_abort_valid", m_valid, 1'b0);

        // Asynchronous reset between edges in the middle of a sweep.
        class_major = 1'b0;
        start       = 1'b1;
        tick();
        start   = 1'b0;
        m_ready = 1'b1;
        repeat (6) tick();
        chk1("pre_reset_valid", m_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("async_reset_valid", m_valid, 1'b0);
        chk1("async_reset_busy", busy, 1'b0);
        chkw("async_reset_beat", obs_beat(), 128'(0));
        chkw("async_reset_rom_addr", 128'({rom_frame_id, rom_frame_index}), 128'(0));
        #2 rst_n = 1'b1;
        m_ready = 1'b0;
        tick();
        chk1("post_reset_busy", busy, 1'b0);
        chk1("post_reset_done", done, 1'b0);

        // Clean sweep after reset, random backpressure.
        run_sweep(1'b1, 1'b1, -1, cyc);
        tick();
        chk1("final_done_drops", done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
